// File: rtl/jtag_uart_pkg.sv
// rtl/jtag_uart_pkg.sv - shared constants, FSM states and entry type for the JTAG-UART transmit encoder
package jtag_uart_pkg;

    localparam logic [7:0] ESC_BYTE = 8'hFE;
    localparam logic [7:0] CMD_IDLE = 8'h00;
    localparam logic [7:0] CMD_ACK  = 8'h01;

    // WSPACE field of the JTAG-UART control register
    localparam int WSPACE_HI = 31;
    localparam int WSPACE_LO = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POLL    = 2'd1,
        ST_WR_ESC  = 2'd2,
        ST_WR_BYTE = 2'd3
    } txState_t;

    typedef struct packed {
        logic       isCmd;
        logic [7:0] data;
    } txEntry_t;

    function automatic logic needsEscape(input logic isCmd, input logic [7:0] b);
        return isCmd || (b == ESC_BYTE);
    endfunction

endpackage

// File: rtl/jtag_uart_tx_fifo.sv
// rtl/jtag_uart_tx_fifo.sv - synchronous FIFO with registered pointers, no fall-through
module jtag_uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iPUSH,
    input  logic [WIDTH-1:0] iDATA,
    input  logic             iPOP,
    output logic [WIDTH-1:0] oQ,
    output logic             oFULL,
    output logic             oEMPTY
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign oFULL  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign oEMPTY = (wrPtr == rdPtr);
    assign doPush = iPUSH && !oFULL;
    assign doPop  = iPOP && !oEMPTY;
    assign oQ     = mem[rdPtr[AW-1:0]];

    always_ff @(posedge iCLK) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= iDATA;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_uart_encode.sv
// rtl/jtag_uart_encode.sv - buffers bytes/commands and writes them 0xFE-escaped to the JTAG-UART data register
// Optional JTAG_UART_ENCODE_WSPACE_POLL_EN: poll WSPACE before each entry so escape pairs are never split or dropped.
import jtag_uart_pkg::*;

module jtag_uart_encode #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oJTAG_SLAVE_ADDR,
    output logic        oJTAG_SLAVE_RDREQ,
    input  logic [31:0] iJTAG_SLAVE_RDDATA,
    output logic        oJTAG_SLAVE_WRREQ,
    output logic [31:0] oJTAG_SLAVE_WRDATA,
    input  logic        iJTAG_SLAVE_WAIT,
    input  logic [7:0]  iTX_DATA,
    input  logic        iTX_IS_CMD,
    input  logic        iTX_VALID,
    output logic        oTX_READY,
    output logic        oBUSY
);

    txState_t   state;
    txEntry_t   fifoIn;
    txEntry_t   fifoQ;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       push;
    logic       pop;
    logic       escNow;
    logic [7:0] curByte;
    logic [7:0] wrData;

    assign fifoIn    = '{isCmd: iTX_IS_CMD, data: iTX_DATA};
    assign push      = iTX_VALID && !fifoFull;
    assign pop       = (state == ST_IDLE) && !fifoEmpty;
    assign escNow    = needsEscape(fifoQ.isCmd, fifoQ.data);
    assign oTX_READY = !fifoFull;
    assign oBUSY     = !fifoEmpty || (state != ST_IDLE);
    assign oJTAG_SLAVE_WRDATA = {24'd0, wrData};

    jtag_uart_tx_fifo #(
        .WIDTH(9),
        .DEPTH(FIFO_DEPTH),
        .AW   (FIFO_AW)
    ) uFifo (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iPUSH (push),
        .iDATA (fifoIn),
        .iPOP  (pop),
        .oQ    (fifoQ),
        .oFULL (fifoFull),
        .oEMPTY(fifoEmpty)
    );

`ifdef JTAG_UART_ENCODE_WSPACE_POLL_EN
    logic        rdReq;
    logic        needEsc;
    logic [15:0] wspace;
    logic [15:0] wspaceNeed;
    logic        unusedRdLow;

    assign oJTAG_SLAVE_RDREQ = rdReq;
    assign wspace      = iJTAG_SLAVE_RDDATA[WSPACE_HI:WSPACE_LO];
    assign wspaceNeed  = needEsc ? 16'd2 : 16'd1;
    assign unusedRdLow = ^iJTAG_SLAVE_RDDATA[WSPACE_LO-1:0];
`else
    logic unusedRdData;

    assign oJTAG_SLAVE_RDREQ = 1'b0;
    assign unusedRdData      = ^iJTAG_SLAVE_RDDATA;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state             <= ST_IDLE;
            curByte           <= 8'd0;
            wrData            <= 8'd0;
            oJTAG_SLAVE_ADDR  <= 1'b0;
            oJTAG_SLAVE_WRREQ <= 1'b0;
`ifdef JTAG_UART_ENCODE_WSPACE_POLL_EN
            rdReq             <= 1'b0;
            needEsc           <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        curByte <= fifoQ.data;
`ifdef JTAG_UART_ENCODE_WSPACE_POLL_EN
                        needEsc          <= escNow;
                        oJTAG_SLAVE_ADDR <= 1'b1;
                        rdReq            <= 1'b1;
                        state            <= ST_POLL;
`else
                        oJTAG_SLAVE_ADDR  <= 1'b0;
                        oJTAG_SLAVE_WRREQ <= 1'b1;
                        wrData            <= escNow ? ESC_BYTE : fifoQ.data;
                        state             <= escNow ? ST_WR_ESC : ST_WR_BYTE;
`endif
                    end
                end
`ifdef JTAG_UART_ENCODE_WSPACE_POLL_EN
                // Insufficient room keeps the read asserted, reissuing it every cycle
                ST_POLL: begin
                    if (!iJTAG_SLAVE_WAIT && (wspace >= wspaceNeed)) begin
                        rdReq             <= 1'b0;
                        oJTAG_SLAVE_ADDR  <= 1'b0;
                        oJTAG_SLAVE_WRREQ <= 1'b1;
                        wrData            <= needEsc ? ESC_BYTE : curByte;
                        state             <= needEsc ? ST_WR_ESC : ST_WR_BYTE;
                    end
                end
`endif
                ST_WR_ESC: begin
                    if (!iJTAG_SLAVE_WAIT) begin
                        wrData <= curByte;
                        state  <= ST_WR_BYTE;
                    end
                end
                ST_WR_BYTE: begin
                    if (!iJTAG_SLAVE_WAIT) begin
                        oJTAG_SLAVE_WRREQ <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: begin
                    oJTAG_SLAVE_ADDR  <= 1'b0;
                    oJTAG_SLAVE_WRREQ <= 1'b0;
                    state             <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_uart_encode.sv
// tb/tb_jtag_uart_encode.sv - directed, table-driven bench for jtag_uart_encode
module tb_jtag_uart_encode;
    import jtag_uart_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        oJTAG_SLAVE_ADDR;
    logic        oJTAG_SLAVE_RDREQ;
    logic [31:0] iJTAG_SLAVE_RDDATA = 32'h00FF_0000;
    logic        oJTAG_SLAVE_WRREQ;
    logic [31:0] oJTAG_SLAVE_WRDATA;
    logic        iJTAG_SLAVE_WAIT = 1'b0;
    logic [7:0]  iTX_DATA = 8'd0;
    logic        iTX_IS_CMD = 1'b0;
    logic        iTX_VALID = 1'b0;
    logic        oTX_READY;
    logic        oBUSY;

    jtag_uart_encode #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .iCLK              (iCLK),
        .iRST              (iRST),
        .oJTAG_SLAVE_ADDR  (oJTAG_SLAVE_ADDR),
        .oJTAG_SLAVE_RDREQ (oJTAG_SLAVE_RDREQ),
        .iJTAG_SLAVE_RDDATA(iJTAG_SLAVE_RDDATA),
        .oJTAG_SLAVE_WRREQ (oJTAG_SLAVE_WRREQ),
        .oJTAG_SLAVE_WRDATA(oJTAG_SLAVE_WRDATA),
        .iJTAG_SLAVE_WAIT  (iJTAG_SLAVE_WAIT),
        .iTX_DATA          (iTX_DATA),
        .iTX_IS_CMD        (iTX_IS_CMD),
        .iTX_VALID         (iTX_VALID),
        .oTX_READY         (oTX_READY),
        .oBUSY             (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Completed writes, captured at the falling edge before the completing rising edge
    logic [7:0]  wrLog [$];
    logic        pValid = 1'b0;
    logic        pHold  = 1'b0;
    logic        pAddr, pRd, pWr;
    logic [31:0] pData;

    always @(negedge iCLK) begin
        if (iRST) begin
            pValid <= 1'b0;
        end else begin
            check1("rd_wr_excl", oJTAG_SLAVE_RDREQ && oJTAG_SLAVE_WRREQ, 1'b0);
            check32("wrdata_hi", {8'd0, oJTAG_SLAVE_WRDATA[31:8]}, 32'd0);
`ifndef JTAG_UART_ENCODE_WSPACE_POLL_EN
            check1("rdreq_tied", oJTAG_SLAVE_RDREQ, 1'b0);
`endif
            if (pValid && pHold) begin
                check1("hold_addr", oJTAG_SLAVE_ADDR, pAddr);
                check1("hold_rd", oJTAG_SLAVE_RDREQ, pRd);
                check1("hold_wr", oJTAG_SLAVE_WRREQ, pWr);
                check32("hold_data", oJTAG_SLAVE_WRDATA, pData);
            end
            if (oJTAG_SLAVE_WRREQ && !iJTAG_SLAVE_WAIT) begin
                wrLog.push_back(oJTAG_SLAVE_WRDATA[7:0]);
            end
            pValid <= 1'b1;
            pHold  <= iJTAG_SLAVE_WAIT && (oJTAG_SLAVE_RDREQ || oJTAG_SLAVE_WRREQ);
            pAddr  <= oJTAG_SLAVE_ADDR;
            pRd    <= oJTAG_SLAVE_RDREQ;
            pWr    <= oJTAG_SLAVE_WRREQ;
            pData  <= oJTAG_SLAVE_WRDATA;
        end
    end

    function automatic logic [31:0] logAt(input int k);
        if (k < wrLog.size()) begin
            return {24'd0, wrLog[k]};
        end
        return 32'hXXXX_XXXX;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic pushOne(input logic isCmd, input logic [7:0] d);
        int n;
        iTX_IS_CMD = isCmd;
        iTX_DATA   = d;
        iTX_VALID  = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge iCLK);
            if (oTX_READY) begin
                tick();
                break;
            end
            tick();
        end
        iTX_VALID = 1'b0;
        check1("push_timeout", n >= 200, 1'b0);
    endtask

    task automatic waitIdle();
        int n;
        for (n = 0; n < 600; n++) begin
            @(negedge iCLK);
            if (!oBUSY) break;
        end
        tick();
        check1("idle_timeout", n >= 600, 1'b0);
    endtask

    typedef struct {
        logic       isCmd;
        logic [7:0] data;
        int         nWr;
        logic [7:0] w0;
        logic [7:0] w1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 8'h41, 1, 8'h41, 8'h00};
        vecs[1] = '{1'b0, 8'h42, 1, 8'h42, 8'h00};
        vecs[2] = '{1'b0, 8'hFE, 2, 8'hFE, 8'hFE};
        vecs[3] = '{1'b1, 8'h01, 2, 8'hFE, 8'h01};
        vecs[4] = '{1'b0, 8'h00, 1, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 8'h00, 2, 8'hFE, 8'h00};
        vecs[6] = '{1'b0, 8'hFD, 1, 8'hFD, 8'h00};
        vecs[7] = '{1'b0, 8'hFF, 1, 8'hFF, 8'h00};

        repeat (3) tick();
        check1("rst_rdreq", oJTAG_SLAVE_RDREQ, 1'b0);
        check1("rst_wrreq", oJTAG_SLAVE_WRREQ, 1'b0);
        check1("rst_addr", oJTAG_SLAVE_ADDR, 1'b0);
        check32("rst_wrdata", oJTAG_SLAVE_WRDATA, 32'd0);
        check1("rst_ready", oTX_READY, 1'b1);
        check1("rst_busy", oBUSY, 1'b0);
        iRST = 1'b0;
        tick();

`ifndef JTAG_UART_ENCODE_WSPACE_POLL_EN
        // Push on N and N+1: writes on N+2 and N+4, busy falls on N+5
        wrLog.delete();
        iTX_VALID = 1'b1; iTX_IS_CMD = 1'b0; iTX_DATA = 8'h41;
        tick();
        iTX_DATA = 8'h42;
        @(negedge iCLK); check1("lat_n1_wrreq", oJTAG_SLAVE_WRREQ, 1'b0);
        tick();
        iTX_VALID = 1'b0;
        @(negedge iCLK); check1("lat_n2_wrreq", oJTAG_SLAVE_WRREQ, 1'b1);
        check32("lat_n2_data", oJTAG_SLAVE_WRDATA, 32'h41);
        tick();
        @(negedge iCLK); check1("lat_n3_wrreq", oJTAG_SLAVE_WRREQ, 1'b0);
        check1("lat_n3_busy", oBUSY, 1'b1);
        tick();
        @(negedge iCLK); check1("lat_n4_wrreq", oJTAG_SLAVE_WRREQ, 1'b1);
        check32("lat_n4_data", oJTAG_SLAVE_WRDATA, 32'h42);
        tick();
        @(negedge iCLK); check1("lat_n5_wrreq", oJTAG_SLAVE_WRREQ, 1'b0);
        check1("lat_n5_busy", oBUSY, 1'b0);
        tick();
        check32("lat_count", wrLog.size(), 32'd2);
`endif

        for (int i = 0; i < 8; i++) begin
            wrLog.delete();
            pushOne(vecs[i].isCmd, vecs[i].data);
            waitIdle();
            check32($sformatf("vec%0d_count", i), wrLog.size(), vecs[i].nWr);
            check32($sformatf("vec%0d_w0", i), logAt(0), {24'd0, vecs[i].w0});
            if (vecs[i].nWr == 2) begin
                check32($sformatf("vec%0d_w1", i), logAt(1), {24'd0, vecs[i].w1});
            end
        end

        // Waitrequest held for three cycles on the escape write
        wrLog.delete();
        pushOne(1'b1, 8'h05);
        for (n = 0; n < 50; n++) begin
            if (oJTAG_SLAVE_WRREQ) begin
                iJTAG_SLAVE_WAIT = 1'b1;
                break;
            end
            tick();
        end
        check1("wait_find", n >= 50, 1'b0);
        repeat (3) begin
            @(negedge iCLK);
            check32("wait_esc_data", oJTAG_SLAVE_WRDATA, 32'hFE);
            check1("wait_esc_addr", oJTAG_SLAVE_ADDR, 1'b0);
            check1("wait_esc_wrreq", oJTAG_SLAVE_WRREQ, 1'b1);
            tick();
        end
        iJTAG_SLAVE_WAIT = 1'b0;
        tick();
        @(negedge iCLK);
        check32("wait_byte_data", oJTAG_SLAVE_WRDATA, 32'h05);
        check1("wait_byte_wrreq", oJTAG_SLAVE_WRREQ, 1'b1);
        tick();
        waitIdle();
        check32("wait_count", wrLog.size(), 32'd2);
        check32("wait_w0", logAt(0), 32'hFE);
        check32("wait_w1", logAt(1), 32'h05);

        // FIFO full: the first entry is taken by the FSM, the next 16 fill the FIFO
        wrLog.delete();
        iJTAG_SLAVE_WAIT = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pushOne(1'b0, 8'h10 + 8'(i));
            check1($sformatf("full_ready%0d", i), oTX_READY, i < 16);
        end
        iTX_IS_CMD = 1'b0; iTX_DATA = 8'h21; iTX_VALID = 1'b1;
        repeat (3) begin
            @(negedge iCLK);
            check1("full_held", oTX_READY, 1'b0);
            tick();
        end
        iJTAG_SLAVE_WAIT = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge iCLK);
            if (oTX_READY) begin
                tick();
                break;
            end
            tick();
        end
        iTX_VALID = 1'b0;
        check1("full_release", n >= 50, 1'b0);
        waitIdle();
        check32("full_count", wrLog.size(), 32'd18);
        for (int i = 0; i < 18; i++) begin
            check32($sformatf("full_order%0d", i), logAt(i), 32'h10 + 32'(i));
        end

        // Reset between the escape and the code byte of a command
        wrLog.delete();
        iTX_VALID = 1'b1; iTX_IS_CMD = 1'b1; iTX_DATA = 8'h07;
        tick();
        iTX_IS_CMD = 1'b0; iTX_DATA = 8'h44;
        tick();
        iTX_VALID = 1'b0;
        for (n = 0; n < 50; n++) begin
            if (oJTAG_SLAVE_WRREQ && oJTAG_SLAVE_WRDATA == 32'hFE) break;
            tick();
        end
        check1("rst_find", n >= 50, 1'b0);
        tick();
        check32("rst_pre_data", oJTAG_SLAVE_WRDATA, 32'h07);
        check1("rst_pre_wrreq", oJTAG_SLAVE_WRREQ, 1'b1);
        iRST = 1'b1;
        #1;
        check1("rst_mid_wrreq", oJTAG_SLAVE_WRREQ, 1'b0);
        check1("rst_mid_rdreq", oJTAG_SLAVE_RDREQ, 1'b0);
        check1("rst_mid_addr", oJTAG_SLAVE_ADDR, 1'b0);
        check32("rst_mid_data", oJTAG_SLAVE_WRDATA, 32'd0);
        check1("rst_mid_busy", oBUSY, 1'b0);
        check1("rst_mid_ready", oTX_READY, 1'b1);
        tick();
        iRST = 1'b0;
        tick();
        check1("rst_post_busy", oBUSY, 1'b0);
        check32("rst_log_count", wrLog.size(), 32'd1);
        check32("rst_log_esc", logAt(0), 32'hFE);
        wrLog.delete();
        pushOne(1'b0, 8'h33);
        waitIdle();
        check32("rst_next_count", wrLog.size(), 32'd1);
        check32("rst_next_byte", logAt(0), 32'h33);

`ifdef JTAG_UART_ENCODE_WSPACE_POLL_EN
        // WSPACE of 1 blocks an escaped entry but lets a plain byte through
        wrLog.delete();
        iJTAG_SLAVE_RDDATA = 32'h0001_0000;
        pushOne(1'b1, CMD_ACK);
        repeat (6) tick();
        @(negedge iCLK);
        check1("poll_rdreq", oJTAG_SLAVE_RDREQ, 1'b1);
        check1("poll_addr", oJTAG_SLAVE_ADDR, 1'b1);
        check32("poll_no_write", wrLog.size(), 32'd0);
        tick();
        iJTAG_SLAVE_RDDATA = 32'h0002_0000;
        waitIdle();
        check32("poll_count", wrLog.size(), 32'd2);
        check32("poll_w0", logAt(0), 32'hFE);
        check32("poll_w1", logAt(1), 32'h01);
        wrLog.delete();
        iJTAG_SLAVE_RDDATA = 32'h0001_0000;
        pushOne(1'b0, 8'h55);
        waitIdle();
        check32("poll_plain_count", wrLog.size(), 32'd1);
        check32("poll_plain_byte", logAt(0), 32'h55);
        iJTAG_SLAVE_RDDATA = 32'h00FF_0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
